// File: rtl/aoc_pkg.sv
// Shared definitions for the digit line feeder: FSM state encoding and ASCII constants.
package aoc_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    FILL,
    START,
    PUSH,
    DONE
  } feeder_state_t;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/digit_line_feeder_if.sv
// Byte-source and stack-side signals of the digit line feeder, bundled for port connection.
interface digit_line_feeder_if #(
  parameter int unsigned DATA_WIDTH = aoc_pkg::DATA_WIDTH_DEF
);
  logic [7:0]            char_in;
  logic                  char_in_valid;
  logic                  char_in_last;
  logic                  char_in_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  stack_ready;
  logic [DATA_WIDTH-1:0] nums_left;
  logic                  line_start;
  logic                  line_done;
  logic                  line_overflow;

  modport master (
    input  char_in, char_in_valid, char_in_last, stack_ready,
    output char_in_ready, data_in, data_in_valid, nums_left,
           line_start, line_done, line_overflow
  );

  modport slave (
    output char_in, char_in_valid, char_in_last, stack_ready,
    input  char_in_ready, data_in, data_in_valid, nums_left,
           line_start, line_done, line_overflow
  );
endinterface

// File: rtl/line_buf.sv
// Simple dual-port digit store: synchronous write, combinational read, no reset on the array.
module line_buf #(
  parameter int unsigned MAX_LINE = 128,
  parameter int unsigned AW       = $clog2(MAX_LINE)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data
);

  logic [3:0] mem [MAX_LINE];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/digit_line_feeder.sv
// Buffers one line of ASCII digits, then replays them to the stack with a per-digit nums_left.
module digit_line_feeder
  import aoc_pkg::*;
#(
  parameter int unsigned MAX_LINE   = 128,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                clock,
  input  logic                reset,
  digit_line_feeder_if.master bus
);

  localparam int unsigned AW = $clog2(MAX_LINE);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_LINE);

  feeder_state_t state;
  logic [CW-1:0] count;
  logic [CW-1:0] rd_ptr;
  logic          ready_q;
  logic          valid_q;
  logic          start_q;
  logic          done_q;
  logic          ovf_q;

  logic          take;
  logic          dig;
  logic          store;
  logic          eol;
  logic [CW-1:0] count_nxt;
  logic [3:0]    rd_data;

  always_comb begin
    take      = (state == FILL) && bus.char_in_valid;
    dig       = is_digit(bus.char_in);
    store     = take && dig && (count != FULL);
    eol       = take && ((bus.char_in == CH_LF) || bus.char_in_last);
    count_nxt = count + CW'(store);
  end

  // Low nibble of an ASCII digit equals its value since '0' is 8'h30.
  line_buf #(
    .MAX_LINE (MAX_LINE)
  ) u_buf (
    .clock   (clock),
    .wr_en   (store),
    .wr_addr (count[AW-1:0]),
    .wr_data (bus.char_in[3:0]),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FILL;
      count   <= '0;
      rd_ptr  <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (take) begin
            if (dig && !store) ovf_q <= 1'b1;
            count <= count_nxt;
            if (eol && (count_nxt != '0)) begin
              state   <= START;
              ready_q <= 1'b0;
              start_q <= 1'b1;
            end
          end
        end
        START: begin
          start_q <= 1'b0;
          rd_ptr  <= '0;
          valid_q <= 1'b1;
          state   <= PUSH;
        end
        PUSH: begin
          if (bus.stack_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == count - 1'b1) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          count   <= '0;
          ready_q <= 1'b1;
          state   <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  // Data outputs are forced to zero outside PUSH so reset and idle show all-zero.
  always_comb begin
    bus.data_in   = valid_q ? DATA_WIDTH'(rd_data) : '0;
    bus.nums_left = valid_q ? DATA_WIDTH'(count - rd_ptr) : '0;
  end

  assign bus.char_in_ready = ready_q;
  assign bus.data_in_valid = valid_q;
  assign bus.line_start    = start_q;
  assign bus.line_done     = done_q;
  assign bus.line_overflow = ovf_q;

endmodule

// File: tb/tb_digit_line_feeder.sv
// Directed self-checking bench for digit_line_feeder built with MAX_LINE=4.
module tb_digit_line_feeder;

  localparam int unsigned DW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  digit_line_feeder_if #(.DATA_WIDTH(DW)) bus();

  digit_line_feeder #(
    .MAX_LINE   (4),
    .DATA_WIDTH (DW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic send_byte(input logic [7:0] c, input logic last);
    int unsigned waited = 0;
    bus.char_in       = c;
    bus.char_in_valid = 1'b1;
    bus.char_in_last  = last;
    while (bus.char_in_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (bus.char_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte 0x%02h: char_in_ready=%b, required 1", c, bus.char_in_ready);
    end
    @(negedge clock);
    bus.char_in_valid = 1'b0;
    bus.char_in_last  = 1'b0;
  endtask

  task automatic send_line(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic expect_start(input string tag);
    checks++;
    if ({bus.line_start, bus.data_in_valid, bus.char_in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL %s start: start/valid/ready=%b%b%b, required 100",
               tag, bus.line_start, bus.data_in_valid, bus.char_in_ready);
    end
    @(negedge clock);
  endtask

  task automatic push_step(input int unsigned d, input int unsigned n, input string tag);
    checks++;
    if ({bus.data_in_valid, bus.data_in, bus.nums_left, bus.char_in_ready, bus.line_start}
        !== {1'b1, DW'(d), DW'(n), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s push: valid=%b data=%0d left=%0d ready=%b, required valid=1 data=%0d left=%0d ready=0",
               tag, bus.data_in_valid, bus.data_in, bus.nums_left, bus.char_in_ready, d, n);
    end
    @(negedge clock);
  endtask

  task automatic expect_done(input string tag);
    checks++;
    if ({bus.line_done, bus.data_in_valid, bus.char_in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL %s done: done/valid/ready=%b%b%b, required 100",
               tag, bus.line_done, bus.data_in_valid, bus.char_in_ready);
    end
    @(negedge clock);
    checks++;
    if ({bus.line_done, bus.line_start, bus.char_in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL %s idle: done/start/ready=%b%b%b, required 001",
               tag, bus.line_done, bus.line_start, bus.char_in_ready);
    end
  endtask

  task automatic test_reset();
    bus.char_in = 8'h00; bus.char_in_valid = 1'b0; bus.char_in_last = 1'b0;
    bus.stack_ready = 1'b1;
    #12;
    checks++;
    if ({bus.char_in_ready, bus.data_in_valid, bus.line_start, bus.line_done, bus.line_overflow,
         bus.data_in, bus.nums_left} !== {5'b10000, DW'(0), DW'(0)}) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b start=%b done=%b ovf=%b data=%0d left=%0d, required ready=1 rest 0",
               bus.char_in_ready, bus.data_in_valid, bus.line_start, bus.line_done,
               bus.line_overflow, bus.data_in, bus.nums_left);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    send_line("987\n", 1'b0);
    expect_start("basic");
    push_step(9, 3, "basic");
    push_step(8, 2, "basic");
    push_step(7, 1, "basic");
    expect_done("basic");
    checks++;
    if (bus.line_overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic ovf: line_overflow=%b, required 0", bus.line_overflow);
    end
  endtask

  task automatic test_ignore();
    send_line("8a1", 1'b0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'h0A, 1'b0);
    expect_start("ignore");
    push_step(8, 2, "ignore");
    push_step(1, 1, "ignore");
    expect_done("ignore");
  endtask

  task automatic test_blank_last();
    for (int i = 0; i < 2; i++) begin
      send_byte(8'h0A, 1'b0);
      checks++;
      if ({bus.line_start, bus.line_done, bus.char_in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL blank%0d: start/done/ready=%b%b%b, required 001",
                 i, bus.line_start, bus.line_done, bus.char_in_ready);
      end
    end
    send_line("12", 1'b1);
    expect_start("last");
    push_step(1, 2, "last");
    push_step(2, 1, "last");
    expect_done("last");
  endtask

  task automatic test_stall();
    send_line("4567\n", 1'b0);
    expect_start("stall");
    push_step(4, 4, "stall");
    bus.stack_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.data_in_valid, bus.data_in, bus.nums_left} !== {1'b1, DW'(5), DW'(3)}) begin
        errors++;
        $display("FAIL stall hold%0d: valid=%b data=%0d left=%0d, required valid=1 data=5 left=3",
                 i, bus.data_in_valid, bus.data_in, bus.nums_left);
      end
      @(negedge clock);
    end
    bus.stack_ready = 1'b1;
    push_step(5, 3, "stall");
    push_step(6, 2, "stall");
    push_step(7, 1, "stall");
    expect_done("stall");
  endtask

  task automatic test_overflow();
    send_line("123456\n", 1'b0);
    checks++;
    if (bus.line_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow set: line_overflow=%b, required 1", bus.line_overflow);
    end
    expect_start("overflow");
    push_step(1, 4, "overflow");
    push_step(2, 3, "overflow");
    push_step(3, 2, "overflow");
    push_step(4, 1, "overflow");
    expect_done("overflow");
    checks++;
    if (bus.line_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow sticky: line_overflow=%b, required 1", bus.line_overflow);
    end
  endtask

  task automatic test_reset_mid();
    send_line("999\n", 1'b0);
    expect_start("midreset");
    push_step(9, 3, "midreset");
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.char_in_ready, bus.data_in_valid, bus.line_start, bus.line_done, bus.line_overflow,
         bus.data_in, bus.nums_left} !== {5'b10000, DW'(0), DW'(0)}) begin
      errors++;
      $display("FAIL async reset: ready=%b valid=%b start=%b done=%b ovf=%b data=%0d left=%0d, required ready=1 rest 0",
               bus.char_in_ready, bus.data_in_valid, bus.line_start, bus.line_done,
               bus.line_overflow, bus.data_in, bus.nums_left);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.line_done, bus.data_in_valid, bus.char_in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL post-reset%0d: done/valid/ready=%b%b%b, required 001",
                 i, bus.line_done, bus.data_in_valid, bus.char_in_ready);
      end
    end
    send_line("5\n", 1'b0);
    expect_start("after reset");
    push_step(5, 1, "after reset");
    expect_done("after reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore();
    test_blank_last();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
